conv_window_sequencer: RTL

- Sequences the 3x3 column-multiplexed convolution datapath over a full output feature map.
- For each output window it:
  - requests the window from the line buffer;
  - steps the three kernel columns through the datapath with `comp_select` and `comp_add`;
  - accumulates the three per-column partial sums at full precision;
  - saturates the total to int8 and presents it on a valid/ready output.
- Sits between the top-level layer controller (start/done) and the comp datapath plus the line buffer.

---
 rtl/conv_window_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/conv_window_sequencer.sv
// ---------------------------------------------------------------------------
// conv_window_sequencer
//
// Walks a 3x3 column-multiplexed convolution datapath across an output
// feature map of OUT_W x OUT_H windows. For each window it requests the window
// from the line buffer, steps the three kernel columns through the datapath,
// accumulates the three per-column partial sums at full precision, saturates
// the total to int8 and presents it on a valid/ready output.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_start        one-cycle pulse, starts a map pass (ignored while busy)
//   o_busy         high while a map pass is in progress
//   o_done         one-cycle pulse after the last window's output handshake
//   o_win_req      window-load request to the line buffer
//   i_win_ack      line buffer has the window ready (sampled only in REQ)
//   o_win_row      output row of the current window
//   o_win_col      output column of the current window
//   o_comp_select  kernel column select to the datapath
//   o_comp_add     datapath sum-register enable
//   i_comp_sum     signed int8 per-column partial sum from the datapath
//   o_out_valid    result valid
//   i_out_ready    downstream accepts the result
//   o_out_data     signed int8 window result
// ---------------------------------------------------------------------------
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start, counters at (0,0)
// REQ    | requesting the current window, waiting for win_ack
// COMP   | five phases stepping kernel columns and accumulating
// OUT    | result presented, waiting for out_ready
// ---------------------------------------------------------------------------
module conv_window_sequencer #(
    parameter int OUT_W = 26,
    parameter int OUT_H = 26,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_win_req,
    input  logic             i_win_ack,
    output logic [CNT_W-1:0] o_win_row,
    output logic [CNT_W-1:0] o_win_col,
    output logic [1:0]       o_comp_select,
    output logic             o_comp_add,
    input  logic [7:0]       i_comp_sum,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [7:0]       o_out_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_COMP = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(OUT_H - 1);

    logic [1:0]        r_state;
    logic [2:0]        r_phase;
    logic signed [9:0] r_acc;
    logic [CNT_W-1:0]  r_row;
    logic [CNT_W-1:0]  r_col;
    logic [7:0]        r_out_data;
    logic              r_done;

    logic signed [9:0] w_sum_ext;
    logic signed [9:0] w_total;
    logic [7:0]        w_sat;
    logic              w_last_col;
    logic              w_last_row;

    assign w_sum_ext  = {{2{i_comp_sum[7]}}, i_comp_sum};
    assign w_total    = r_acc + w_sum_ext;
    assign w_last_col = (r_col == LAST_COL);
    assign w_last_row = (r_row == LAST_ROW);

    // Only the final total is clamped; the three-column sum fits in 10 bits.
    always_comb begin
        w_sat = w_total[7:0];
        if (w_total > 10'sd127) begin
            w_sat = 8'h7F;
        end else if (w_total < -10'sd128) begin
            w_sat = 8'h80;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_phase    <= 3'd0;
            r_acc      <= 10'sd0;
            r_row      <= '0;
            r_col      <= '0;
            r_out_data <= 8'd0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_REQ;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                S_REQ: begin
                    if (i_win_ack) begin
                        r_state <= S_COMP;
                        r_phase <= 3'd0;
                        r_acc   <= 10'sd0;
                    end
                end
                S_COMP: begin
                    r_phase <= r_phase + 3'd1;
                    // The sum register trails comp_add by a cycle, so column 0
                    // arrives in phase 2 and column 2 in phase 4.
                    case (r_phase)
                        3'd2:    r_acc <= w_sum_ext;
                        3'd3:    r_acc <= w_total;
                        3'd4: begin
                            r_out_data <= w_sat;
                            r_phase    <= 3'd0;
                            r_state    <= S_OUT;
                        end
                        default: ;
                    endcase
                end
                S_OUT: begin
                    if (i_out_ready) begin
                        if (w_last_row && w_last_col) begin
                            r_state <= S_IDLE;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            if (w_last_col) begin
                                r_col <= '0;
                                r_row <= r_row + CNT_W'(1);
                            end else begin
                                r_col <= r_col + CNT_W'(1);
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Phase 3 holds select at 2: the product register already carries
    // column 2 and only the sum register still has to capture it.
    always_comb begin
        o_comp_select = 2'd0;
        o_comp_add    = 1'b0;
        if (r_state == S_COMP) begin
            case (r_phase)
                3'd1: begin
                    o_comp_select = 2'd1;
                    o_comp_add    = 1'b1;
                end
                3'd2, 3'd3: begin
                    o_comp_select = 2'd2;
                    o_comp_add    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_win_req   = (r_state == S_REQ);
    assign o_win_row   = r_row;
    assign o_win_col   = r_col;
    assign o_out_valid = (r_state == S_OUT);
    assign o_out_data  = r_out_data;

endmodule
